// File: rtl/i2c_pkg.sv
// Shared constants for the single-byte I2C master: FSM state codes,
// quarter-phase numbering within a bit slot, and the default SCL divider.
package i2c_pkg;

  localparam int CLK_DIV_DEFAULT = 4;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_START     = 4'd1;
  localparam logic [3:0] ST_ADDR      = 4'd2;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd3;
  localparam logic [3:0] ST_WDATA     = 4'd4;
  localparam logic [3:0] ST_WDATA_ACK = 4'd5;
  localparam logic [3:0] ST_RDATA     = 4'd6;
  localparam logic [3:0] ST_MNACK     = 4'd7;
  localparam logic [3:0] ST_STOP      = 4'd8;

  // Quarter phases of a bit slot: SCL low for Q0/Q1, high for Q2/Q3.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Command/status and bus-pin bundle of the I2C master, with the controller
// side (master) and the requester/line side (slave) views.
interface i2c_master_ctrl_if;

  // start is a one-cycle strobe, taken only while busy is low; done pulses
  // for one cycle in the same cycle busy falls, and rdata is valid with it.
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       scl;
  logic       sda_oe;
  logic       sda_in;

  modport master (
    input  start, addr, rw, wdata, sda_in,
    output rdata, busy, done, ack_err, scl, sda_oe
  );

  modport slave (
    output start, addr, rw, wdata, sda_in,
    input  rdata, busy, done, ack_err, scl, sda_oe
  );

endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider: one-cycle tick every CLK_DIV enabled cycles,
// restarted from zero by clear.
module i2c_tick_gen
  import i2c_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = en && !clear && (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: START, address+rw, one data byte written or
// read (read ends with master NACK), then STOP. Fixed 4-quarter bit slots.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

  logic [3:0] state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;

  logic       accept;
  logic       tick;
  logic       last_bit;

  assign accept   = start && !busy_q;
  assign last_bit = (bit_q == 3'd7);

  i2c_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_q),
    .clear(accept),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;

    if (accept) begin
      state_d   = ST_START;
      qtr_d     = Q0;
      bit_d     = 3'd0;
      sh_d      = {addr, rw};
      rw_d      = rw;
      wdata_d   = wdata;
      busy_d    = 1'b1;
      ack_err_d = 1'b0;
    end else if (busy_q && tick) begin
      qtr_d = qtr_q + 2'd1;

      // Entering Q3: SCL has just been high for a quarter, so SDA is settled.
      if (qtr_q == Q2) begin
        if ((state_q == ST_ADDR_ACK || state_q == ST_WDATA_ACK) && sda_in) begin
          ack_err_d = 1'b1;
        end
        if (state_q == ST_RDATA) begin
          rx_d = {rx_q[6:0], sda_in};
        end
      end

      if (qtr_q == Q3) begin
        case (state_q)
          ST_START: begin
            state_d = ST_ADDR;
            bit_d   = 3'd0;
          end
          ST_ADDR: begin
            sh_d = {sh_q[6:0], 1'b0};
            if (last_bit) begin
              state_d = ST_ADDR_ACK;
              bit_d   = 3'd0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          ST_ADDR_ACK: begin
            // ack_err_q can only have been set by this slot's sample here.
            if (ack_err_q) begin
              state_d = ST_STOP;
            end else if (rw_q) begin
              state_d = ST_RDATA;
            end else begin
              state_d = ST_WDATA;
              sh_d    = wdata_q;
            end
            bit_d = 3'd0;
          end
          ST_WDATA: begin
            sh_d = {sh_q[6:0], 1'b0};
            if (last_bit) begin
              state_d = ST_WDATA_ACK;
              bit_d   = 3'd0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          ST_WDATA_ACK: begin
            state_d = ST_STOP;
          end
          ST_RDATA: begin
            if (last_bit) begin
              state_d = ST_MNACK;
              bit_d   = 3'd0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          ST_MNACK: begin
            state_d = ST_STOP;
          end
          ST_STOP: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (rw_q && !ack_err_q) begin
              rdata_d = rx_q;
            end
          end
          default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        endcase
      end
    end
  end

  // Pin decode: START pulls SDA while SCL is high, STOP releases it while high.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state_q)
      ST_START: begin
        scl    = (qtr_q != Q3);
        sda_oe = (qtr_q == Q2) || (qtr_q == Q3);
      end
      ST_ADDR, ST_WDATA: begin
        scl    = qtr_q[1];
        sda_oe = ~sh_q[7];
      end
      ST_ADDR_ACK, ST_WDATA_ACK, ST_RDATA, ST_MNACK: begin
        scl    = qtr_q[1];
        sda_oe = 1'b0;
      end
      ST_STOP: begin
        scl    = qtr_q[1];
        sda_oe = (qtr_q == Q0) || (qtr_q == Q1) || (qtr_q == Q2);
      end
      default: begin
        scl    = 1'b1;
        sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      qtr_q     <= Q0;
      bit_q     <= 3'd0;
      sh_q      <= 8'd0;
      rx_q      <= 8'd0;
      rdata_q   <= 8'd0;
      wdata_q   <= 8'd0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a cycle-sampled I2C slave/bus monitor.
module tb_i2c_master_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int FULL_CYC = 321;
  localparam int NACK_CYC = 177;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_master_ctrl_if bus ();

  logic slave_low = 1'b0;
  assign bus.sda_in = !(bus.sda_oe || slave_low);

  i2c_master_ctrl #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (bus.start),
    .addr   (bus.addr),
    .rw     (bus.rw),
    .wdata  (bus.wdata),
    .rdata  (bus.rdata),
    .busy   (bus.busy),
    .done   (bus.done),
    .ack_err(bus.ack_err),
    .scl    (bus.scl),
    .sda_oe (bus.sda_oe),
    .sda_in (bus.sda_in)
  );

  int checks = 0;
  int errors = 0;

  logic       addr_ack_en = 1'b1;
  logic       data_ack_en = 1'b1;
  logic [7:0] rd_byte     = 8'h00;

  logic [7:0] byte_q[$];
  logic       ack_q[$];
  logic [7:0] exp_q[$];
  int         start_cnt = 0;
  int         stop_cnt  = 0;

  // Slave/monitor: decodes START/STOP and bits on SCL rise, drives on SCL fall.
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;
  logic       in_txn = 1'b0;
  logic       rd_mode = 1'b0;
  logic [7:0] mon_sh = 8'h00;
  int         rise_n = 0;

  always @(negedge clk) begin
    logic line;
    line = !(bus.sda_oe || slave_low);
    if (rst) begin
      in_txn    = 1'b0;
      rise_n    = 0;
      slave_low = 1'b0;
      scl_p     = 1'b1;
      sda_p     = 1'b1;
    end else begin
      if (scl_p && bus.scl && sda_p && !line) begin
        start_cnt++;
        in_txn    = 1'b1;
        rise_n    = 0;
        slave_low = 1'b0;
      end else if (scl_p && bus.scl && !sda_p && line) begin
        stop_cnt++;
        in_txn    = 1'b0;
        slave_low = 1'b0;
      end else if (in_txn && !scl_p && bus.scl) begin
        if (rise_n % 9 == 8) begin
          ack_q.push_back(line);
        end else begin
          mon_sh = {mon_sh[6:0], line};
          if (rise_n % 9 == 7) begin
            byte_q.push_back(mon_sh);
            if (rise_n == 7) rd_mode = mon_sh[0];
          end
        end
        rise_n++;
      end else if (in_txn && scl_p && !bus.scl) begin
        slave_low = 1'b0;
        if (rise_n == 8) slave_low = addr_ack_en;
        else if (rise_n >= 9 && rise_n < 17 && rd_mode) slave_low = ~rd_byte[16-rise_n];
        else if (rise_n == 17 && !rd_mode) slave_low = data_ack_en;
      end
      scl_p = bus.scl;
      sda_p = !(bus.sda_oe || slave_low);
    end
  end

  task automatic mon_clear();
    byte_q.delete();
    ack_q.delete();
    exp_q.delete();
    start_cnt = 0;
    stop_cnt  = 0;
  endtask

  // Called just after a rising edge; that next edge is the accept edge.
  task automatic do_start(input logic [6:0] a, input logic r, input logic [7:0] w);
    bus.start = 1'b1;
    bus.addr  = a;
    bus.rw    = r;
    bus.wdata = w;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // cyc counts edges since the accept edge; -1 on timeout.
  task automatic wait_done(input int cyc0, input int max_cyc, output int cyc);
    cyc = cyc0;
    while (bus.done !== 1'b1 && cyc <= max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (bus.done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.addr  = 7'h00;
    bus.rw    = 1'b0;
    bus.wdata = 8'h00;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.scl !== 1'b1) begin errors++; $display("FAIL reset_scl got %b exp 1", bus.scl); end
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b exp 0", bus.sda_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got %b exp 0", bus.ack_err); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", bus.rdata); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    int cyc;
    mon_clear();
    addr_ack_en = 1'b1;
    data_ack_en = 1'b1;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA5);
    do_start(7'h50, 1'b0, 8'hA5);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_rise got %b exp 1", bus.busy); end
    wait_done(1, 400, cyc);
    checks++; if (cyc !== FULL_CYC) begin errors++; $display("FAIL wr_done_cycle got %0d exp %0d", cyc, FULL_CYC); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_at_done got %b exp 0", bus.busy); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL wr_ack_err got %b exp 0", bus.ack_err); end
    checks++; if (byte_q.size() !== exp_q.size()) begin errors++; $display("FAIL wr_byte_count got %0d exp %0d", byte_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      checks++; if (byte_q[i] !== exp_q[i]) begin errors++; $display("FAIL wr_byte%0d got %h exp %h", i, byte_q[i], exp_q[i]); end
    end
    checks++; if (ack_q.size() !== 2 || ack_q[0] !== 1'b0 || ack_q[1] !== 1'b0) begin
      errors++; $display("FAIL wr_acks got size %0d exp 2 slave ACKs", ack_q.size());
    end
    checks++; if (start_cnt !== 1 || stop_cnt !== 1) begin errors++; $display("FAIL wr_start_stop got %0d/%0d exp 1/1", start_cnt, stop_cnt); end
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL wr_done_width got %b exp 0", bus.done); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_untouched got %h exp 00", bus.rdata); end
  endtask

  task automatic test_read();
    int cyc;
    mon_clear();
    rd_byte = 8'h3C;
    do_start(7'h50, 1'b1, 8'h00);
    wait_done(1, 400, cyc);
    checks++; if (cyc !== FULL_CYC) begin errors++; $display("FAIL rd_done_cycle got %0d exp %0d", cyc, FULL_CYC); end
    checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata got %h exp 3c", bus.rdata); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL rd_ack_err got %b exp 0", bus.ack_err); end
    checks++; if (byte_q.size() !== 2) begin errors++; $display("FAIL rd_byte_count got %0d exp 2", byte_q.size()); end
    if (byte_q.size() >= 1) begin
      checks++; if (byte_q[0] !== 8'hA1) begin errors++; $display("FAIL rd_addr_byte got %h exp a1", byte_q[0]); end
    end
    checks++; if (ack_q.size() !== 2) begin
      errors++; $display("FAIL rd_ack_count got %0d exp 2", ack_q.size());
    end else begin
      checks++; if (ack_q[0] !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b exp 0", ack_q[0]); end
      checks++; if (ack_q[1] !== 1'b1) begin errors++; $display("FAIL rd_master_nack got %b exp 1", ack_q[1]); end
    end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata_hold got %h exp 3c", bus.rdata); end
  endtask

  task automatic test_addr_nack();
    int cyc;
    mon_clear();
    addr_ack_en = 1'b0;
    do_start(7'h50, 1'b0, 8'hFF);
    wait_done(1, 400, cyc);
    checks++; if (cyc !== NACK_CYC) begin errors++; $display("FAIL nack_done_cycle got %0d exp %0d", cyc, NACK_CYC); end
    checks++; if (bus.ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err got %b exp 1", bus.ack_err); end
    checks++; if (byte_q.size() !== 1) begin errors++; $display("FAIL nack_byte_count got %0d exp 1", byte_q.size()); end
    checks++; if (stop_cnt !== 1) begin errors++; $display("FAIL nack_stop got %0d exp 1", stop_cnt); end
    checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL nack_rdata_hold got %h exp 3c", bus.rdata); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err_hold got %b exp 1", bus.ack_err); end
    addr_ack_en = 1'b1;
  endtask

  task automatic test_busy_start();
    int cyc;
    mon_clear();
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h5A);
    do_start(7'h50, 1'b0, 8'h5A);
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL busy_ack_err_clear got %b exp 0", bus.ack_err); end
    repeat (99) @(posedge clk);
    #1;
    do_start(7'h11, 1'b1, 8'hFF);
    wait_done(101, 400, cyc);
    checks++; if (cyc !== FULL_CYC) begin errors++; $display("FAIL busy_done_cycle got %0d exp %0d", cyc, FULL_CYC); end
    checks++; if (start_cnt !== 1) begin errors++; $display("FAIL busy_start_count got %0d exp 1", start_cnt); end
    checks++; if (byte_q.size() !== exp_q.size()) begin errors++; $display("FAIL busy_byte_count got %0d exp %0d", byte_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      checks++; if (byte_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_byte%0d got %h exp %h", i, byte_q[i], exp_q[i]); end
    end
    checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL busy_rdata got %h exp 3c", bus.rdata); end
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_idle_after got %b exp 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    mon_clear();
    do_start(7'h50, 1'b0, 8'h00);
    repeat (241) @(posedge clk);
    #1;
    checks++; if (bus.scl !== 1'b0 || bus.sda_oe !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_state got scl=%b oe=%b busy=%b exp 0/1/1", bus.scl, bus.sda_oe, bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.scl !== 1'b1) begin errors++; $display("FAIL rst_mid_scl got %b exp 1", bus.scl); end
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_sda_oe got %b exp 0", bus.sda_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_rdata got %h exp 00", bus.rdata); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
      @(posedge clk);
      #1;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d active cycles exp 0", seen_done); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    mon_clear();
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h0F);
    do_start(7'h50, 1'b0, 8'hA5);
    wait_done(1, 400, cyc);
    checks++; if (cyc !== FULL_CYC) begin errors++; $display("FAIL b2b_first_done got %0d exp %0d", cyc, FULL_CYC); end
    do_start(7'h2A, 1'b0, 8'h0F);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b exp 1", bus.busy); end
    wait_done(1, 400, cyc);
    checks++; if (cyc !== FULL_CYC) begin errors++; $display("FAIL b2b_second_done got %0d exp %0d", cyc, FULL_CYC); end
    checks++; if (start_cnt !== 2 || stop_cnt !== 2) begin errors++; $display("FAIL b2b_start_stop got %0d/%0d exp 2/2", start_cnt, stop_cnt); end
    checks++; if (byte_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_byte_count got %0d exp %0d", byte_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      checks++; if (byte_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, byte_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 The block SHALL have one parameter, one per line: CLK_DIV, 4, clk cycles per SCL quarter-bit (legal values 2..255).
REQ-002 Port: clk  input  1  sole clock; all logic is on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle command strobe.
REQ-005 Port: addr  input  7  target slave address.
REQ-006 Port: rw  input  1  direction: 0 = write, 1 = read.
REQ-007 Port: wdata  input  8  write byte.
REQ-008 Port: rdata  output  8  read byte, valid while done is high.
REQ-009 Port: busy  output  1  transaction in progress.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: ack_err  output  1  a slave NACK occurred in the last transaction.
REQ-012 Port: scl  output  1  SCL line, push-pull; no clock stretching.
REQ-013 Port: sda_oe  output  1  drives SDA low when 1 and releases SDA when 0 (open-drain).
REQ-014 Port: sda_in  input  1  sampled SDA line level.

Function
REQ-015 start SHALL be accepted only while busy=0 and ignored while busy=1. On accept, addr, rw and wdata SHALL be latched and busy SHALL rise on the next cycle.
REQ-016 A quarter-tick SHALL occur every CLK_DIV clk cycles while busy=1. The tick counter SHALL restart at each accept.
REQ-017 Every bit slot SHALL be 4 quarters: q0 scl=0 with SDA updated; q1 scl=0; q2 scl=1; q3 scl=1 with sda_in sampled on entry.
REQ-018 FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, MNACK and STOP.
REQ-019 The START state (4 quarters) SHALL proceed as follows:
- q0–q1: scl=1, sda_oe=0.
- q2: sda_oe=1 while scl=1.
- q3: scl=0.
REQ-020 ADDR SHALL shift {addr,rw} MSB-first over 8 slots, with sda_oe = ~bit.
REQ-021 In ADDR_ACK and WDATA_ACK, sda_oe SHALL be 0. sda_in=1 at q3 SHALL set ack_err.
REQ-022 If ADDR_ACK samples NACK, the FSM SHALL go directly to STOP and skip the data byte.
REQ-023 After ADDR_ACK, the FSM SHALL go to WDATA when rw=0 and to RDATA when rw=1.
REQ-024 WDATA SHALL shift wdata MSB-first. WDATA_ACK SHALL then go to STOP regardless of the ACK value.
REQ-025 RDATA SHALL hold sda_oe=0 and shift sda_in into rdata MSB-first at each q3. MNACK SHALL then hold sda_oe=0 for one slot (master NACK).
REQ-026 The STOP state (4 quarters) SHALL proceed as follows:
- q0–q1: scl=0, sda_oe=1.
- q2: scl=1.
- q3: sda_oe=0.
REQ-027 The transaction length SHALL be fixed:
- Full write or read: 80 quarters, with done asserted exactly 80*CLK_DIV+1 cycles after the accept cycle.
- Address NACK: 44 quarters, with done asserted 44*CLK_DIV+1 cycles after the accept cycle.
REQ-028 On completion, busy SHALL fall and done SHALL pulse in the same cycle.
REQ-029 ack_err SHALL clear on accept and hold its value until the next accept.
REQ-030 rdata SHALL hold its value until the next read completes. A write transaction SHALL not alter rdata.
REQ-031 A start arriving in the same cycle that done is high SHALL be accepted, because busy is already 0 in that cycle.
REQ-032 In IDLE, the outputs SHALL be scl=1 and sda_oe=0.

Reset
REQ-033 Assertion of rst at any time, including mid-transaction, SHALL immediately force the following:
- state=IDLE and all counters = 0.
- scl=1, sda_oe=0.
- busy=0, done=0, ack_err=0, rdata=8'h00.
REQ-034 Any transaction interrupted by reset SHALL be abandoned, with no done pulse.

Structure
REQ-035 The state enum, the quarter-phase constants and the CLK_DIV default SHALL reside in shared package i2c_pkg.
REQ-036 The quarter-tick divider SHALL be a sub-module named i2c_tick_gen (inputs clk, rst, en, clear; output tick).

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Write, CLK_DIV=4, addr=7'h50, wdata=8'hA5, slave ACKs: SDA bytes read 8'hA0 then 8'hA5; done at cycle 321; ack_err=0.
- Read, addr=7'h50, slave returns 8'h3C: address byte 8'hA1; rdata=8'h3C at done; master NACK observed on slot 9.
- Address NACK: ack_err=1; no data byte on the bus; done at cycle 177.
- start while busy, mid-transaction: ignored; the current transaction completes unchanged.
- rst asserted during WDATA: same cycle scl=1, sda_oe=0, busy=0; no done pulse.
- Back-to-back: start in the same cycle as done is accepted; a second START condition is observed.
